// File: rtl/op_pkg.sv
// ----------------------------------------------------------------------------
// op_pkg
//   Shared definitions for the N-operand floating-point reduction block:
//   controller state encoding, format widths, operand limits and a few
//   IEEE-754 single-precision constants.
// ----------------------------------------------------------------------------
package op_pkg;

    localparam int unsigned FP_WIDTH   = 32;
    localparam int unsigned MAX_INPUTS = 16;

    localparam logic [FP_WIDTH-1:0] FP_ZERO = 32'h0000_0000;
    localparam logic [FP_WIDTH-1:0] FP_ONE  = 32'h3F80_0000;
    localparam logic [FP_WIDTH-1:0] FP_QNAN = 32'h7FC0_0000;
    localparam logic [FP_WIDTH-1:0] FP_PINF = 32'h7F80_0000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_ACK,
        ST_WAIT_RES,
        ST_NEXT,
        ST_OUTPUT
    } state_e;

    // Flip the sign of an operand when neg is set.
    function automatic logic [FP_WIDTH-1:0] fp_cond_negate(
        input logic [FP_WIDTH-1:0] x,
        input logic                neg
    );
        return {x[FP_WIDTH-1] ^ neg, x[FP_WIDTH-2:0]};
    endfunction

endpackage

// File: rtl/op_reduce_add_adder.sv
// ----------------------------------------------------------------------------
// op_reduce_add_adder
//   Single-precision floating-point adder core with STB/BUSY handshakes on
//   both sides. Round-to-nearest-even; denormal inputs and results are
//   flushed to zero; NaN/Inf are propagated (Inf - Inf gives a quiet NaN).
//
//   Ports:
//     clk_i       clock (rising edge)
//     rst_ni      asynchronous active-low reset
//     in_stb_i    operands a_i/b_i valid; accepted when !busy_o
//     a_i, b_i    operands
//     busy_o      high from accept until the result has been taken
//     result_o    sum, valid while out_stb_o
//     out_stb_o   result valid
//     out_busy_i  consumer busy; result taken when out_stb_o && !out_busy_i
// ----------------------------------------------------------------------------
module op_reduce_add_adder
    import op_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                in_stb_i,
    input  logic [FP_WIDTH-1:0] a_i,
    input  logic [FP_WIDTH-1:0] b_i,
    output logic                busy_o,
    output logic [FP_WIDTH-1:0] result_o,
    output logic                out_stb_o,
    input  logic                out_busy_i
);

    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
        logic [31:0]        x, y;
        logic [7:0]         ex, ey, d;
        logic [26:0]        mx, my, mys, mask;
        logic [27:0]        sum;
        logic signed [9:0]  e;
        logic [4:0]         lz;
        logic               rnd;
        logic [24:0]        mr;

        // Ordering the 31 magnitude bits as integers orders the values.
        if (a[30:0] >= b[30:0]) begin
            x = a; y = b;
        end else begin
            x = b; y = a;
        end
        ex = x[30:23];
        ey = y[30:23];

        if (ex == 8'hFF) begin
            if (x[22:0] != 23'd0)                        return FP_QNAN;
            if ((ey == 8'hFF) && (x[31] != y[31]))       return FP_QNAN;
            return x;
        end
        if (ey == 8'd0) begin
            if (ex == 8'd0) return {a[31] & b[31], 31'd0};
            return x;
        end

        // Three extra LSBs hold guard, round and sticky.
        mx = {1'b1, x[22:0], 3'b000};
        my = {1'b1, y[22:0], 3'b000};
        d  = ex - ey;
        if (d >= 8'd27) begin
            mys = 27'd1;
        end else begin
            mask = (27'd1 << d) - 27'd1;
            mys  = my >> d;
            mys[0] = mys[0] | (|(my & mask));
        end

        e = $signed({2'b00, ex});
        if (x[31] == y[31]) begin
            sum = {1'b0, mx} + {1'b0, mys};
            if (sum[27]) begin
                sum = {1'b0, sum[27:2], sum[1] | sum[0]};
                e   = e + 10'sd1;
            end
        end else begin
            sum = {1'b0, mx} - {1'b0, mys};
            if (sum == 28'd0) return FP_ZERO;
            lz = 5'd0;
            for (int unsigned i = 0; i < 27; i++) begin
                if (sum[i]) lz = 5'(26 - i);
            end
            sum = sum << lz;
            e   = e - $signed({5'b00000, lz});
        end

        rnd = sum[2] & (sum[1] | sum[0] | sum[3]);
        mr  = {1'b0, sum[26:3]} + {24'd0, rnd};
        if (mr[24]) begin
            mr = mr >> 1;
            e  = e + 10'sd1;
        end

        if (e <= 10'sd0)   return {x[31], 31'd0};
        if (e >= 10'sd255) return {x[31], FP_PINF[30:0]};
        return {x[31], e[7:0], mr[22:0]};
    endfunction

    logic [FP_WIDTH-1:0] a_q, b_q, res_q;
    logic                busy_q, pend_q, out_stb_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            a_q       <= '0;
            b_q       <= '0;
            res_q     <= '0;
            busy_q    <= 1'b0;
            pend_q    <= 1'b0;
            out_stb_q <= 1'b0;
        end else if (!busy_q) begin
            if (in_stb_i) begin
                a_q    <= a_i;
                b_q    <= b_i;
                busy_q <= 1'b1;
                pend_q <= 1'b1;
            end
        end else if (pend_q) begin
            res_q     <= fp_add(a_q, b_q);
            out_stb_q <= 1'b1;
            pend_q    <= 1'b0;
        end else if (out_stb_q && !out_busy_i) begin
            out_stb_q <= 1'b0;
            busy_q    <= 1'b0;
        end
    end

    assign busy_o    = busy_q;
    assign result_o  = res_q;
    assign out_stb_o = out_stb_q;

endmodule

// File: rtl/op_reduce_add.sv
// ----------------------------------------------------------------------------
// op_reduce_add
//   Sums N_INPUTS single-precision operands as a left fold in index order
//   (acc = x0; acc = acc + x[i]) through one shared adder core.
//
//   Parameters: N_INPUTS (1..16), WIDTH (must be 32).
//   Ports:
//     clk                 clock (rising edge)
//     rst                 asynchronous active-low reset
//     input_vec           operands, element i at [i*WIDTH +: WIDTH]
//     opN_input_STB       input_vec valid; accepted when !opN_BUSY
//     opN_BUSY            transaction in progress
//     output_result       final sum, valid while opN_output_STB
//     opN_output_STB      result valid
//     output_module_BUSY  downstream busy; transfer on STB && !BUSY
//     neg_mask            per-operand negate (only with OPN_NEG_EN)
//
//   Build option: define OPN_NEG_EN to add neg_mask.
// ----------------------------------------------------------------------------
module op_reduce_add
    import op_pkg::*;
#(
    parameter int N_INPUTS = 4,
    parameter int WIDTH    = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_INPUTS*WIDTH-1:0] input_vec,
    input  logic                      opN_input_STB,
    output logic                      opN_BUSY,
    output logic [WIDTH-1:0]          output_result,
    output logic                      opN_output_STB,
    input  logic                      output_module_BUSY
`ifdef OPN_NEG_EN
    ,
    input  logic [N_INPUTS-1:0]       neg_mask
`endif
);

    if (WIDTH != FP_WIDTH) begin : g_width_chk
        $error("op_reduce_add: WIDTH must be 32");
    end
    if ((N_INPUTS < 1) || (N_INPUTS > MAX_INPUTS)) begin : g_count_chk
        $error("op_reduce_add: N_INPUTS must be in 1..16");
    end

    localparam logic [3:0] LAST_IDX = 4'(N_INPUTS - 1);

    state_e              state_q;
    logic [3:0]          idx_q;
    logic [FP_WIDTH-1:0] acc_q;
    logic [FP_WIDTH-1:0] opnd_q [MAX_INPUTS];
    logic [FP_WIDTH-1:0] opnd_d [MAX_INPUTS];
    logic                adder_in_stb_q;
    logic                adder_out_busy_q;

    logic                adder_busy;
    logic                adder_out_stb;
    logic [FP_WIDTH-1:0] adder_result;

    // Operand storage is always MAX_INPUTS deep so the 4-bit index never
    // selects past the array; unused slots capture zero.
    logic [MAX_INPUTS*FP_WIDTH-1:0] vec_pad;
    logic [MAX_INPUTS-1:0]          mask_pad;

    assign vec_pad = (MAX_INPUTS*FP_WIDTH)'(input_vec);
`ifdef OPN_NEG_EN
    assign mask_pad = MAX_INPUTS'(neg_mask);
`else
    assign mask_pad = '0;
`endif

    always_comb begin
        for (int unsigned i = 0; i < MAX_INPUTS; i++) begin
            opnd_d[i] = fp_cond_negate(vec_pad[i*FP_WIDTH +: FP_WIDTH], mask_pad[i]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q          <= ST_IDLE;
            idx_q            <= '0;
            acc_q            <= '0;
            adder_in_stb_q   <= 1'b0;
            adder_out_busy_q <= 1'b1;
            opN_BUSY         <= 1'b0;
            opN_output_STB   <= 1'b0;
            output_result    <= '0;
            for (int unsigned i = 0; i < MAX_INPUTS; i++) opnd_q[i] <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (opN_input_STB && !opN_BUSY) begin
                        for (int unsigned i = 0; i < MAX_INPUTS; i++) opnd_q[i] <= opnd_d[i];
                        acc_q    <= opnd_d[0];
                        idx_q    <= 4'd1;
                        opN_BUSY <= 1'b1;
                        state_q  <= (N_INPUTS == 1) ? ST_OUTPUT : ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    adder_in_stb_q <= 1'b1;
                    state_q        <= ST_WAIT_ACK;
                end
                ST_WAIT_ACK: begin
                    // The adder has taken the operands once it reports busy.
                    if (adder_busy) begin
                        adder_in_stb_q   <= 1'b0;
                        adder_out_busy_q <= 1'b0;
                        state_q          <= ST_WAIT_RES;
                    end
                end
                ST_WAIT_RES: begin
                    if (adder_out_stb && !adder_out_busy_q) begin
                        acc_q            <= adder_result;
                        adder_out_busy_q <= 1'b1;
                        state_q          <= ST_NEXT;
                    end
                end
                ST_NEXT: begin
                    if (idx_q == LAST_IDX) begin
                        state_q <= ST_OUTPUT;
                    end else begin
                        idx_q   <= idx_q + 4'd1;
                        state_q <= ST_ISSUE;
                    end
                end
                ST_OUTPUT: begin
                    // First cycle presents the result; it then holds until taken.
                    if (!opN_output_STB) begin
                        output_result  <= acc_q;
                        opN_output_STB <= 1'b1;
                    end else if (!output_module_BUSY) begin
                        opN_output_STB <= 1'b0;
                        opN_BUSY       <= 1'b0;
                        idx_q          <= '0;
                        state_q        <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    op_reduce_add_adder u_adder (
        .clk_i      (clk),
        .rst_ni     (rst),
        .in_stb_i   (adder_in_stb_q),
        .a_i        (acc_q),
        .b_i        (opnd_q[idx_q]),
        .busy_o     (adder_busy),
        .result_o   (adder_result),
        .out_stb_o  (adder_out_stb),
        .out_busy_i (adder_out_busy_q)
    );

endmodule
